// File: rtl/sha256_msg_sched_pkg.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched_pkg
// Shared constants and types for the SHA-256 message-schedule datapath:
// word width, round count, sliding-window depth, the rotate/shift amounts
// used by the small sigma functions, and the scheduler state encoding.
// ---------------------------------------------------------------------------
package sha256_msg_sched_pkg;

  localparam int WORD_W    = 32;
  localparam int ROUNDS    = 64;
  localparam int WIN_DEPTH = 16;
  localparam int BLOCK_W   = WORD_W * WIN_DEPTH;
  localparam int T_W       = 6;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  localparam logic [T_W-1:0] LAST_T = T_W'(ROUNDS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sha256_msg_sched_small_sigma.sv
// ---------------------------------------------------------------------------
// sha256_small_sigma
// Combinational SHA-256 small sigma function.
//   SEL_SIGMA1 = 0 : y_o = sigma0(x_i)
//   SEL_SIGMA1 = 1 : y_o = sigma1(x_i)
// Ports:
//   x_i  input  [31:0]  operand word
//   y_o  output [31:0]  sigma result
// ---------------------------------------------------------------------------
module sha256_small_sigma
  import sha256_msg_sched_pkg::*;
#(
  parameter bit SEL_SIGMA1 = 1'b0
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  localparam int ROT_A = SEL_SIGMA1 ? S1_ROT_A : S0_ROT_A;
  localparam int ROT_B = SEL_SIGMA1 ? S1_ROT_B : S0_ROT_B;
  localparam int SHR_N = SEL_SIGMA1 ? S1_SHR   : S0_SHR;

  logic [WORD_W-1:0] rot_a_s;
  logic [WORD_W-1:0] rot_b_s;
  logic [WORD_W-1:0] shr_s;

  // Rotations are pure rewiring of the operand bits.
  assign rot_a_s = {x_i[ROT_A-1:0], x_i[WORD_W-1:ROT_A]};
  assign rot_b_s = {x_i[ROT_B-1:0], x_i[WORD_W-1:ROT_B]};
  assign shr_s   = x_i >> SHR_N;

  assign y_o = rot_a_s ^ rot_b_s ^ shr_s;

endmodule

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// SHA-256 message schedule generator. Accepts one 512-bit block and streams
// the 64 schedule words W[0..63] with a valid/ready handshake, using a
// 16-word sliding window: slot0 is always the word on offer, and each
// transfer shifts the window down and appends the next derived word.
// Ports:
//   clk       input         rising-edge clock
//   rst       input         synchronous active-high reset
//   load      input         request to accept block_in (honoured in IDLE only)
//   block_in  input  [511:0] message block, M0 in [511:480] .. M15 in [31:0]
//   ready     output        idle, able to accept load
//   w_out     output [31:0] current schedule word W[t]
//   t_out     output [5:0]  index t of w_out
//   w_valid   output        w_out/t_out valid
//   w_ready   input         downstream consumes the word this cycle
//   done      output        pulses in the cycle W[63] is consumed
// ---------------------------------------------------------------------------
module sha256_msg_sched
  import sha256_msg_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               ready,
  output logic [WORD_W-1:0]  w_out,
  output logic [T_W-1:0]     t_out,
  output logic               w_valid,
  input  logic               w_ready,
  output logic               done
);

  state_t            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [WORD_W-1:0] win_q [WIN_DEPTH];
  logic [WORD_W-1:0] win_d [WIN_DEPTH];

  logic [WORD_W-1:0] sig0_s;
  logic [WORD_W-1:0] sig1_s;
  logic [WORD_W-1:0] w_new_s;
  logic              xfer_s;

  sha256_small_sigma #(.SEL_SIGMA1(1'b0)) u_sigma0 (
    .x_i (win_q[1]),
    .y_o (sig0_s)
  );

  sha256_small_sigma #(.SEL_SIGMA1(1'b1)) u_sigma1 (
    .x_i (win_q[14]),
    .y_o (sig1_s)
  );

  // Window positions map to W[t-16], W[t-15], W[t-7], W[t-2] relative to
  // the word being appended at slot15.
  assign w_new_s = sig1_s + win_q[9] + sig0_s + win_q[0];

  assign xfer_s  = (state_q == ST_RUN) && w_ready;

  assign ready   = (state_q == ST_IDLE);
  assign w_valid = (state_q == ST_RUN);
  assign w_out   = win_q[0];
  assign t_out   = t_q;
  assign done    = xfer_s && (t_q == LAST_T);

  // Next-state computation for FSM, index and window.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    for (int k = 0; k < WIN_DEPTH; k++) begin
      win_d[k] = win_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          for (int k = 0; k < WIN_DEPTH; k++) begin
            win_d[k] = block_in[BLOCK_W-1-WORD_W*k -: WORD_W];
          end
          t_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          for (int k = 0; k < WIN_DEPTH-1; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[WIN_DEPTH-1] = w_new_s;
          if (t_q == LAST_T) begin
            // Final word consumed: no wrap inside RUN, go idle.
            t_d     = '0;
            state_d = ST_IDLE;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset also clears the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      for (int k = 0; k < WIN_DEPTH; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int k = 0; k < WIN_DEPTH; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_sched
// Self-checking bench for sha256_msg_sched. Expected schedule words come
// from the textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) +
// W[t-16] evaluated over a 64-entry array.
// ---------------------------------------------------------------------------
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [511:0] block_in;
  logic         ready;
  logic [31:0]  w_out;
  logic [5:0]   t_out;
  logic         w_valid;
  logic         w_ready;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  sha256_msg_sched dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .block_in (block_in),
    .ready    (ready),
    .w_out    (w_out),
    .t_out    (t_out),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[511-32*t -: 32];
      else        exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 after the accepting edge.
  task automatic start_block(input logic [511:0] blk, input bit keep_load, input logic [511:0] next_blk);
    check_eq("ready_before_load", ready, 1);
    check_eq("w_valid_before_load", w_valid, 0);
    build_model(blk);
    load = 1'b1;
    block_in = blk;
    @(posedge clk); #1;
    load = keep_load;
    block_in = next_blk;
  endtask

  // mode 0: w_ready=1, mode 1: pattern 1,0,0,1, mode 2: random.
  // abort_at: apply reset when t reaches it; inj_at: pulse load with a foreign block.
  task automatic run_block(input int mode, input int abort_at, input int inj_at);
    int k = 0;
    int cyc = 0;
    bit wr;
    while (k < 64 && cyc < 1000) begin
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        w_ready = 1'b0;
        check_eq("rst_w_valid", w_valid, 0);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_t_out", t_out, 0);
        check_eq("rst_w_out", w_out, 0);
        check_eq("rst_done", done, 0);
        return;
      end
      case (mode)
        0:       wr = 1'b1;
        1:       wr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: wr = 1'($urandom_range(0, 1));
      endcase
      w_ready = wr;
      if (k == inj_at) begin
        load = 1'b1;
        block_in = rand_block();
      end
      #1;
      check_eq("w_valid", w_valid, 1);
      check_eq("t_out", t_out, k);
      check_eq("w_out", w_out, exp_w[k]);
      check_eq("done", done, (wr && k == 63));
      got_w[k] = w_out;
      @(posedge clk); #1;
      if (k == inj_at) load = 1'b0;
      if (wr) k++;
      cyc++;
    end
    w_ready = 1'b0;
    check_eq("transfer_count", k, 64);
  endtask

  task automatic check_idle_after_done();
    check_eq("ready_after_done", ready, 1);
    check_eq("w_valid_after_done", w_valid, 0);
    check_eq("done_after_done", done, 0);
  endtask

  initial begin
    logic [511:0] abc;
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    abc = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

    // Reset with a concurrent load: load must be ignored.
    rst = 1'b1;
    load = 1'b1;
    w_ready = 1'b1;
    block_in = rand_block();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    load = 1'b0;
    check_eq("reset_ready", ready, 1);
    check_eq("reset_w_valid", w_valid, 0);
    check_eq("reset_t_out", t_out, 0);
    check_eq("reset_w_out", w_out, 0);
    check_eq("reset_done", done, 0);
    w_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_hold_ready", ready, 1);

    // "abc" block, continuous consumption.
    start_block(abc, 1'b0, rand_block());
    run_block(0, -1, -1);
    check_eq("abc_W0", got_w[0], 32'h61626380);
    check_eq("abc_W15", got_w[15], 32'h00000018);
    check_eq("abc_W16", got_w[16], 32'h61626380);
    check_eq("abc_W17", got_w[17], 32'h000F0000);
    check_idle_after_done();

    // All-zero block.
    start_block('0, 1'b0, rand_block());
    run_block(0, -1, -1);
    check_idle_after_done();

    // "abc" with w_ready toggled 1,0,0,1.
    start_block(abc, 1'b0, rand_block());
    run_block(1, -1, -1);
    check_eq("abc_tog_W17", got_w[17], 32'h000F0000);
    check_idle_after_done();

    // Reset mid-run at t=20, then restart with a new block.
    start_block(rand_block(), 1'b0, rand_block());
    run_block(2, 20, -1);
    start_block(rand_block(), 1'b0, rand_block());
    run_block(0, -1, -1);
    check_idle_after_done();

    // Foreign load at t=10 must be ignored.
    start_block(abc, 1'b0, rand_block());
    run_block(0, -1, 10);
    check_eq("inj_W63", got_w[63], exp_w[63]);
    check_idle_after_done();

    // Back-to-back blocks with load held high.
    blk_a = rand_block();
    blk_b = rand_block();
    start_block(blk_a, 1'b1, blk_b);
    run_block(0, -1, -1);
    check_eq("b2b_gap_ready", ready, 1);
    check_eq("b2b_gap_w_valid", w_valid, 0);
    @(posedge clk); #1;
    load = 1'b0;
    block_in = rand_block();
    check_eq("b2b_second_w_valid", w_valid, 1);
    check_eq("b2b_second_t_out", t_out, 0);
    build_model(blk_b);
    run_block(0, -1, -1);
    check_idle_after_done();

    // Random blocks with random back-pressure.
    for (int r = 0; r < 3; r++) begin
      start_block(rand_block(), 1'b0, rand_block());
      run_block(2, -1, -1);
      check_idle_after_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
